// File: rtl/aes_block_loader_if.sv
// Plaintext word stream in, assembled 128-bit block stream out.
// The loader uses the slave view; the upstream source / cipher side uses master.
interface aes_block_loader_if;
    logic [31:0]  in_word;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_block;
    logic         out_valid;
    logic         out_ready;

    modport slave (
        input  in_word,
        input  in_valid,
        output in_ready,
        output out_block,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_word,
        output in_valid,
        input  in_ready,
        input  out_block,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/aes_block_loader.sv
// Packs 32-bit plaintext words into 128-bit AES blocks (byte 0 in the MSBs)
// and queues completed blocks in a DEPTH-entry FIFO ahead of the cipher core.
module aes_block_loader #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    aes_block_loader_if.slave  bus,
    output logic [1:0]         word_idx,
    output logic [CNT_W-1:0]   blk_count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [1:0]       word_idx_q, word_idx_d;
    logic [95:0]      asm_q, asm_d;
    logic [127:0]     mem_q [DEPTH];
    logic [127:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_fire;
    logic push;
    logic pop;

    // Lane 3 is never stored: it is taken straight from in_word on the push edge.
    assign pop          = bus.out_valid && bus.out_ready;
    assign bus.in_ready = (word_idx_q != 2'd3) || (cnt_q < CNT_FULL) || pop;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign push         = in_fire && (word_idx_q == 2'd3);

    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_block = mem_q[head_q];
    assign word_idx      = word_idx_q;
    assign blk_count     = cnt_q;

    always_comb begin
        word_idx_d = word_idx_q;
        asm_d      = asm_q;
        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;

        if (clr) begin
            word_idx_d = '0;
            asm_d      = '0;
            head_d     = '0;
            tail_d     = '0;
            cnt_d      = '0;
        end else begin
            if (in_fire) begin
                case (word_idx_q)
                    2'd0:    asm_d[95:64] = bus.in_word;
                    2'd1:    asm_d[63:32] = bus.in_word;
                    2'd2:    asm_d[31:0]  = bus.in_word;
                    default: ;
                endcase
                word_idx_d = word_idx_q + 2'd1;
            end

            // When full, a same-edge pop frees the head slot that tail now points at.
            if (push) begin
                mem_d[tail_q] = {asm_q, bus.in_word};
                tail_d        = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
            end

            if (pop) begin
                head_d = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
            end

            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx_q <= '0;
            asm_q      <= '0;
            mem_q      <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            word_idx_q <= word_idx_d;
            asm_q      <= asm_d;
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_aes_block_loader.sv
// Directed and throttled-stream checks for aes_block_loader with DEPTH = 2.
module tb_aes_block_loader;
    logic       clk;
    logic       rst_n;
    logic       clr;
    logic [1:0] word_idx;
    logic [3:0] blk_count;

    int n_tests;
    int n_fail;

    aes_block_loader_if bus ();

    aes_block_loader #(.DEPTH(2), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .bus       (bus.slave),
        .word_idx  (word_idx),
        .blk_count (blk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat_word(int b, int w);
        return {8'hA0, 8'(b), 8'(w), 8'h5A};
    endfunction

    function automatic logic [127:0] pat_blk(int b);
        return {pat_word(b, 0), pat_word(b, 1), pat_word(b, 2), pat_word(b, 3)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_word = '0;
        bus.out_ready = 1'b0;
        #12;
        n_tests++;
        if (word_idx !== 2'd0 || blk_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_counts: word_idx=%0d blk_count=%0d expected 0/0", word_idx, blk_count);
        end
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
        end
        n_tests++;
        if (bus.out_block !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_block: got %h expected 0", bus.out_block);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_word = 32'h00112233 + 32'(i) * 32'h44444444;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_block !== 128'h00112233445566778899aabbccddeeff) begin
            n_fail++;
            $display("FAIL basic_block: valid=%b block=%h expected 1/00112233445566778899aabbccddeeff",
                     bus.out_valid, bus.out_block);
        end
        n_tests++;
        if (blk_count !== 4'd1 || word_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL basic_counts: blk_count=%0d word_idx=%0d expected 1/0", blk_count, word_idx);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (blk_count !== 4'd0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pop: blk_count=%0d out_valid=%b expected 0/0", blk_count, bus.out_valid);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_word = pat_word(i / 4, i % 4);
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_word = pat_word(2, 3);
        #1;
        n_tests++;
        if (blk_count !== 4'd2 || word_idx !== 2'd3 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: blk_count=%0d word_idx=%0d in_ready=%b expected 2/3/0",
                     blk_count, word_idx, bus.in_ready);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (word_idx !== 2'd3 || blk_count !== 4'd2) begin
            n_fail++;
            $display("FAIL bp_stall: word_idx=%0d blk_count=%0d expected 3/2", word_idx, blk_count);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_block !== pat_blk(0)) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b block=%h expected 1/%h", bus.in_ready, bus.out_block, pat_blk(0));
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (word_idx !== 2'd0 || blk_count !== 4'd2 || bus.out_block !== pat_blk(1)) begin
            n_fail++;
            $display("FAIL bp_pushpop: word_idx=%0d blk_count=%0d block=%h expected 0/2/%h",
                     word_idx, blk_count, bus.out_block, pat_blk(1));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (blk_count !== 4'd1 || bus.out_block !== pat_blk(2)) begin
            n_fail++;
            $display("FAIL bp_order: blk_count=%0d block=%h expected 1/%h", blk_count, bus.out_block, pat_blk(2));
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (blk_count !== 4'd0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: blk_count=%0d out_valid=%b expected 0/0", blk_count, bus.out_valid);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] sb [$];
        logic [95:0]  acc;
        int           mw;
        int           nout;
        logic [127:0] exp_blk;
        acc = '0;
        mw = 0;
        nout = 0;
        for (int k = 0; k < 88; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_word = $urandom;
            bus.out_ready = (k >= 8) && (k % 4 == 3);
            #1;
            n_tests++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_in_ready k=%0d: got %b expected 1", k, bus.in_ready);
            end
            if (bus.out_valid && bus.out_ready) begin
                exp_blk = (sb.size() > 0) ? sb.pop_front() : 128'hx;
                nout++;
                n_tests++;
                if (bus.out_block !== exp_blk) begin
                    n_fail++;
                    $display("FAIL b2b_block k=%0d: got %h expected %h", k, bus.out_block, exp_blk);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                if (mw == 3) sb.push_back({acc, bus.in_word});
                acc = {acc[63:0], bus.in_word};
                mw = (mw + 1) % 4;
            end
            @(posedge clk);
            #1;
            if (k >= 7) begin
                n_tests++;
                if (blk_count !== 4'd2) begin
                    n_fail++;
                    $display("FAIL b2b_count k=%0d: got %0d expected 2", k, blk_count);
                end
            end
        end
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            n_tests++;
            if (bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_drain_valid: got %b expected 1", bus.out_valid);
            end else begin
                exp_blk = sb.pop_front();
                nout++;
                if (bus.out_block !== exp_blk) begin
                    n_fail++;
                    $display("FAIL b2b_drain_block: got %h expected %h", bus.out_block, exp_blk);
                end
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_tests++;
        if (nout !== 22 || blk_count !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_total: blocks out=%0d blk_count=%0d expected 22/0", nout, blk_count);
        end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_word = 32'hDEAD0000 + 32'(i);
            @(posedge clk);
        end
        @(negedge clk);
        clr = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_word = 32'hBAD0BAD0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_in_ready: got %b expected 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (word_idx !== 2'd0 || blk_count !== 4'd0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_state: word_idx=%0d blk_count=%0d out_valid=%b expected 0/0/0",
                     word_idx, blk_count, bus.out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clr = 1'b0;
            bus.out_ready = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_word = 32'h00010203 + 32'(i) * 32'h04040404;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (bus.out_valid !== 1'b1 || blk_count !== 4'd1 ||
            bus.out_block !== 128'h000102030405060708090a0b0c0d0e0f) begin
            n_fail++;
            $display("FAIL clr_clean_block: valid=%b count=%0d block=%h expected 1/1/000102030405060708090a0b0c0d0e0f",
                     bus.out_valid, blk_count, bus.out_block);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_word = 32'hC0DE0000 + 32'(i);
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_tests++;
        if (blk_count !== 4'd1 || word_idx !== 2'd3) begin
            n_fail++;
            $display("FAIL arst_pre: blk_count=%0d word_idx=%0d expected 1/3", blk_count, word_idx);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (blk_count !== 4'd0 || word_idx !== 2'd0 || bus.out_valid !== 1'b0 ||
            bus.in_ready !== 1'b1 || bus.out_block !== 128'h0) begin
            n_fail++;
            $display("FAIL arst_immediate: count=%0d idx=%0d valid=%b ready=%b block=%h expected 0/0/0/1/0",
                     blk_count, word_idx, bus.out_valid, bus.in_ready, bus.out_block);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [127:0] sb [$];
        logic [95:0]  acc;
        logic [127:0] held;
        logic [127:0] exp_blk;
        logic [31:0]  cur_word;
        logic         stall_prev;
        int           mw;
        int           sent;
        int           nout;
        acc = '0;
        mw = 0;
        sent = 0;
        nout = 0;
        stall_prev = 1'b0;
        held = '0;
        cur_word = $urandom;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (stall_prev) begin
                n_tests++;
                if (bus.out_valid !== 1'b1 || bus.out_block !== held) begin
                    n_fail++;
                    $display("FAIL rnd_stable c=%0d: valid=%b block=%h expected 1/%h", c, bus.out_valid, bus.out_block, held);
                end
            end
            bus.in_valid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.in_word = cur_word;
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.out_valid && bus.out_ready) begin
                exp_blk = (sb.size() > 0) ? sb.pop_front() : 128'hx;
                nout++;
                n_tests++;
                if (bus.out_block !== exp_blk) begin
                    n_fail++;
                    $display("FAIL rnd_block %0d: got %h expected %h", nout, bus.out_block, exp_blk);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                if (mw == 3) sb.push_back({acc, bus.in_word});
                acc = {acc[63:0], bus.in_word};
                mw = (mw + 1) % 4;
                sent++;
                cur_word = $urandom;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held = bus.out_block;
            if (sent == 1000 && nout == 250) break;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        n_tests++;
        if (sent !== 1000 || nout !== 250 || sb.size() !== 0) begin
            n_fail++;
            $display("FAIL rnd_total: words=%0d blocks=%0d pending=%0d expected 1000/250/0", sent, nout, sb.size());
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_clr();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
